// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin arbiter in front of a shared external ALU
module alu_arbiter #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic [2:0]       op0,
   input  logic [2:0]       op1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             gnt0,
   output logic             gnt1,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_cntrl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_negative,
   input  logic             alu_zero,
   input  logic             alu_overflow,
   input  logic             alu_carry,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic [3:0]       rsp_flags,
   input  logic             rsp_ready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             last_gnt_q, last_gnt_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [2:0]       alu_cntrl_q, alu_cntrl_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic [3:0]       rsp_flags_q, rsp_flags_d;

   logic grant;
   logic sel;

   // Arbitration: grant only from IDLE and never while reset is held; on a tie the
   // requester that did not win last time is chosen.
   always_comb begin
      grant = 1'b0;
      sel   = 1'b0;
      if (state_q == IDLE && !reset && (req0 || req1)) begin
         grant = 1'b1;
         if (req0 && req1) begin
            sel = ~last_gnt_q;
         end else begin
            sel = req1;
         end
      end
      gnt0 = grant && !sel;
      gnt1 = grant && sel;
   end

   // Next-state and register update logic for the IDLE -> EXEC -> RESP sequence.
   always_comb begin
      state_d      = state_q;
      last_gnt_d   = last_gnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_cntrl_d  = alu_cntrl_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      case (state_q)
         IDLE: begin
            if (grant) begin
               alu_a_d     = sel ? a1 : a0;
               alu_b_d     = sel ? b1 : b0;
               alu_cntrl_d = sel ? op1 : op0;
               rsp_id_d    = sel;
               last_gnt_d  = sel;
               state_d     = EXEC;
            end
         end
         EXEC: begin
            rsp_result_d = alu_result;
            rsp_flags_d  = {alu_negative, alu_zero, alu_overflow, alu_carry};
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
         end
         RESP: begin
            if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_gnt_q   <= 1'b1;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_cntrl_q  <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_gnt_q   <= last_gnt_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_cntrl_q  <= alu_cntrl_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_cntrl  = alu_cntrl_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
   localparam int W = 64;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req0 = 1'b0, req1 = 1'b0;
   logic [2:0]    op0 = '0, op1 = '0;
   logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic          gnt0, gnt1;
   logic [W-1:0]  alu_a, alu_b, alu_result;
   logic [2:0]    alu_cntrl;
   logic          alu_negative, alu_zero, alu_overflow, alu_carry;
   logic          rsp_valid, rsp_id;
   logic [W-1:0]  rsp_result;
   logic [3:0]    rsp_flags;
   logic          rsp_ready = 1'b1;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   bit   rdy_rand = 1'b0;
   logic rdy_val  = 1'b1;

   logic [67:0] exp_q0[$];
   logic [67:0] exp_q1[$];
   logic        glog_id[$];
   int          glog_cyc[$];

   alu_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .op0(op0), .op1(op1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl),
      .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
      .alu_overflow(alu_overflow), .alu_carry(alu_carry),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_flags(rsp_flags), .rsp_ready(rsp_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference ALU: returns {negative, zero, overflow, carry, result}.
   function automatic logic [67:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0]   s;
      logic [W-1:0] r;
      logic         v, c;
      v = 1'b0;
      c = 1'b0;
      s = '0;
      case (op)
         3'b000: r = b;
         3'b010: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[W-1:0];
            c = s[W];
            v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         3'b011: begin
            s = {1'b0, a} + {1'b0, ~b} + 65'd1;
            r = s[W-1:0];
            c = s[W];
            v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
         end
         3'b100: r = a & b;
         3'b101: r = a | b;
         3'b110: r = a ^ b;
         3'b001: r = a;
         default: r = ~b;
      endcase
      return {r[W-1], (r == '0), v, c, r};
   endfunction

   always_comb {alu_negative, alu_zero, alu_overflow, alu_carry, alu_result} = alu_ref(alu_cntrl, alu_a, alu_b);

   always @(posedge clk) begin
      #1;
      rsp_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
   end

   task automatic check(input string name, input logic [67:0] got, input logic [67:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Monitor: arbitration rules, latency, stability and scoreboard compare.
   logic          busy = 1'b0, last_id = 1'b1, exp_id;
   int            gnt_cyc = 0;
   logic          prev_valid = 1'b0, prev_ready = 1'b0, prev_id = 1'b0, prev_gnt = 1'b1;
   logic [W-1:0]  prev_res = '0, prev_a = '0, prev_b = '0;
   logic [3:0]    prev_flags = '0;
   logic [2:0]    prev_cntrl = '0;
   logic [67:0]   e;
   always @(negedge clk) begin
      if (reset) begin
         busy       = 1'b0;
         last_id    = 1'b1;
         prev_valid = 1'b0;
         prev_gnt   = 1'b1;
      end else begin
         if (!busy && (req0 || req1)) check("grant_when_idle", 68'(gnt0 | gnt1), 68'(1));
         if (busy) check("no_grant_when_busy", 68'(gnt0 | gnt1), 68'(0));
         if (gnt0 | gnt1) begin
            check("grant_exclusive", 68'(gnt0 & gnt1), 68'(0));
            exp_id = (req0 && req1) ? ~last_id : req1;
            check("arb_winner", 68'(gnt1), 68'(exp_id));
            last_id = gnt1;
            gnt_cyc = cyc;
            busy    = 1'b1;
            glog_id.push_back(gnt1);
            glog_cyc.push_back(cyc);
         end
         if (!prev_gnt) begin
            check("alu_a_hold", 68'(alu_a), 68'(prev_a));
            check("alu_b_hold", 68'(alu_b), 68'(prev_b));
            check("alu_cntrl_hold", 68'(alu_cntrl), 68'(prev_cntrl));
         end
         if (rsp_valid && !prev_valid) check("rsp_latency", 68'(cyc - gnt_cyc), 68'(2));
         if (rsp_valid && prev_valid && !prev_ready) begin
            check("rsp_id_hold", 68'(rsp_id), 68'(prev_id));
            check("rsp_result_hold", 68'(rsp_result), 68'(prev_res));
            check("rsp_flags_hold", 68'(rsp_flags), 68'(prev_flags));
         end
         if (rsp_valid && rsp_ready) begin
            if (rsp_id ? (exp_q1.size() == 0) : (exp_q0.size() == 0)) begin
               check("sb_pending", 68'(rsp_id ? exp_q1.size() : exp_q0.size()), 68'(1));
            end else begin
               e = rsp_id ? exp_q1.pop_front() : exp_q0.pop_front();
               check("rsp_data", {rsp_flags, rsp_result}, e);
            end
            busy = 1'b0;
         end
         prev_valid = rsp_valid;
         prev_ready = rsp_ready;
         prev_id    = rsp_id;
         prev_res   = rsp_result;
         prev_flags = rsp_flags;
         prev_gnt   = gnt0 | gnt1;
      end
      prev_a     = alu_a;
      prev_b     = alu_b;
      prev_cntrl = alu_cntrl;
   end

   task automatic issue(input bit id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [67:0] exp);
      bit got;
      got = 1'b0;
      if (!id) begin
         op0 = op; a0 = a; b0 = b; req0 = 1'b1; exp_q0.push_back(exp);
      end else begin
         op1 = op; a1 = a; b1 = b; req1 = 1'b1; exp_q1.push_back(exp);
      end
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         got = id ? gnt1 : gnt0;
      end
      if (!got) check("grant_timeout", 68'(got), 68'(1));
      @(posedge clk);
      #1;
      if (!id) req0 = 1'b0; else req1 = 1'b0;
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         done = (exp_q0.size() == 0) && (exp_q1.size() == 0) && !rsp_valid;
      end
      if (!done) check("drain_timeout", 68'(done), 68'(1));
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   function automatic logic [W-1:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return '1;
         2: return 64'h7FFF_FFFF_FFFF_FFFF;
         3: return 64'h8000_0000_0000_0000;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic rand_loop(input bit id, input int n);
      logic [2:0]   op;
      logic [W-1:0] a, b;
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         op = 3'($urandom_range(0, 7));
         a  = rand_operand();
         b  = rand_operand();
         issue(id, op, a, b, alu_ref(op, a, b));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, with both requests high: no grant may appear.
      req0 = 1'b1; req1 = 1'b1; op0 = 3'b010; a0 = 64'd9; b0 = 64'd9;
      repeat (2) @(negedge clk);
      check("rst_gnt0", 68'(gnt0), 68'(0));
      check("rst_gnt1", 68'(gnt1), 68'(0));
      check("rst_rsp_valid", 68'(rsp_valid), 68'(0));
      check("rst_rsp_id", 68'(rsp_id), 68'(0));
      check("rst_alu_a", 68'(alu_a), 68'(0));
      check("rst_alu_b", 68'(alu_b), 68'(0));
      check("rst_alu_cntrl", 68'(alu_cntrl), 68'(0));
      check("rst_rsp_result", 68'(rsp_result), 68'(0));
      check("rst_rsp_flags", 68'(rsp_flags), 68'(0));
      @(posedge clk);
      #1;
      reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
      @(posedge clk);
      #1;

      // Simple add, then register contents during EXEC.
      issue(1'b0, 3'b010, 64'd5, 64'd7, {4'b0000, 64'd12});
      check("exec_alu_cntrl", 68'(alu_cntrl), 68'(3'b010));
      check("exec_alu_a", 68'(alu_a), 68'(5));
      check("exec_alu_b", 68'(alu_b), 68'(7));
      drain();
      issue(1'b1, 3'b011, 64'd5, 64'd5, {4'b0101, 64'd0});
      drain();
      issue(1'b0, 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, {4'b1010, 64'h8000_0000_0000_0000});
      drain();

      // Reset during EXEC aborts the operation.
      issue(1'b0, 3'b010, 64'd100, 64'd3, {4'b0000, 64'd103});
      reset = 1'b1;
      @(negedge clk);
      check("abort_rsp_valid", 68'(rsp_valid), 68'(0));
      check("abort_alu_a", 68'(alu_a), 68'(0));
      check("abort_alu_b", 68'(alu_b), 68'(0));
      check("abort_alu_cntrl", 68'(alu_cntrl), 68'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_no_rsp", 68'(rsp_valid), 68'(0));
      end
      exp_q0.delete();
      @(posedge clk);
      #1;
      issue(1'b0, 3'b000, 64'd77, 64'hFF, {4'b0000, 64'hFF});
      drain();

      // Both requesters saturating: alternating grants every 3 cycles, 0 first.
      pulse_reset();
      glog_id.delete();
      glog_cyc.delete();
      fork
         for (int k = 0; k < 4; k++) issue(1'b0, 3'b101, 64'(k), 64'h10, {4'b0000, 64'(k) | 64'h10});
         for (int k = 0; k < 4; k++) issue(1'b1, 3'b110, 64'(k), 64'hF0, {4'b0000, 64'(k) ^ 64'hF0});
      join
      drain();
      check("rr_count", 68'(glog_id.size()), 68'(8));
      for (int i = 0; i < glog_id.size() && i < 8; i++) begin
         check("rr_order", 68'(glog_id[i]), 68'(i % 2));
         if (i > 0) check("rr_spacing", 68'(glog_cyc[i] - glog_cyc[i-1]), 68'(3));
      end

      // Back-pressure: response held 5 cycles while req1 waits.
      rdy_val = 1'b0;
      @(posedge clk);
      #1;
      issue(1'b0, 3'b100, 64'hF0F0, 64'hFF00, {4'b0000, 64'hF000});
      fork
         issue(1'b1, 3'b010, 64'd1, 64'd2, {4'b0000, 64'd3});
         begin
            for (int i = 0; i < 6; i++) begin
               @(negedge clk);
               check("bp_no_gnt1", 68'(gnt1), 68'(0));
               if (i > 0) check("bp_valid", 68'(rsp_valid), 68'(1));
            end
            rdy_val = 1'b1;
            @(negedge clk);
            check("bp_accept", 68'(rsp_valid & rsp_ready), 68'(1));
            @(negedge clk);
            check("bp_next_gnt1", 68'(gnt1), 68'(1));
         end
      join
      drain();

      // Randomized traffic with random back-pressure.
      rdy_rand = 1'b1;
      fork
         rand_loop(1'b0, 30);
         rand_loop(1'b1, 30);
      join
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, default 64, operand, result and ALU bus width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0, req1  input  1 each  request from requester 0 and 1; held high until the matching gnt.
REQ-005 op0, op1  input  3 each  ALU cntrl code per requester: 000 pass-B, 010 add, 011 sub, 100 and, 101 or, 110 xor.
REQ-006 a0, b0, a1, b1  input  WIDTH each  operands per requester; stable while req high.
REQ-007 gnt0, gnt1  output  1 each  one-cycle grant pulse; operands of the granted requester are captured on that edge.
REQ-008 alu_a, alu_b  output  WIDTH each  registered operands driven to the shared ALU.
REQ-009 alu_cntrl  output  3  registered op code driven to the shared ALU.
REQ-010 alu_result  input  WIDTH  ALU result.
REQ-011 alu_negative, alu_zero, alu_overflow, alu_carry  input  1 each  ALU flags.
REQ-012 rsp_valid  output  1  response holds valid data.
REQ-013 rsp_id  output  1  requester index owning the response.
REQ-014 rsp_result  output  WIDTH  registered ALU result.
REQ-015 rsp_flags  output  4  registered flags {negative, zero, overflow, carry}.
REQ-016 rsp_ready  input  1  consumer accepts the response when high with rsp_valid.

Function
REQ-017 FSM states SHALL be IDLE, EXEC and RESP.
REQ-018 In IDLE with any req high, the block SHALL select one requester and assert its gnt combinationally in that cycle, latch its op/a/b into alu_cntrl/alu_a/alu_b and its index into rsp_id on the edge, then enter EXEC.
REQ-019 Selection: only one req high -> that requester; both high -> the requester not granted last (round-robin via last_gnt register, updated on every grant).
REQ-020 gnt0 and gnt1 SHALL never be high together and SHALL be low in EXEC and RESP.
REQ-021 EXEC SHALL last exactly one cycle; on its closing edge alu_result and the four flags SHALL be captured into rsp_result/rsp_flags, rsp_valid set to 1, and the state SHALL move to RESP.
REQ-022 Request-to-rsp_valid latency: grant at cycle T -> rsp_valid high at cycle T+2.
REQ-023 In RESP, rsp_valid, rsp_id, rsp_result and rsp_flags SHALL hold stable until rsp_valid && rsp_ready; on that edge rsp_valid SHALL clear and the state SHALL return to IDLE.
REQ-024 New requests arriving in EXEC or RESP SHALL wait, with no grant, until IDLE; the earliest next grant is the cycle after acceptance, so the throughput is one operation per 3 cycles.
REQ-025 alu_a, alu_b and alu_cntrl SHALL change only on a grant edge and hold their values otherwise.
REQ-026 Op codes SHALL pass through unmodified, including the unlisted codes 001 and 111; result interpretation belongs to the consumer.
REQ-027 A requester dropping req without a grant SHALL be tolerated; in IDLE only the current req levels are considered.
REQ-028 If rsp_ready is already high on the first RESP cycle, the response SHALL be accepted in that same cycle.

Reset
REQ-029 While reset is high (asynchronous assert), the state SHALL be IDLE; rsp_valid, gnt0, gnt1 and rsp_id SHALL be 0; alu_a, alu_b, rsp_result, rsp_flags and alu_cntrl SHALL be 0; last_gnt SHALL be 1, so req0 wins the first tie.
REQ-030 Reset asserted in EXEC or RESP SHALL abort the operation without producing a response; after release the block SHALL grant normally from IDLE.
REQ-031 Reset deassertion SHALL take effect on the following rising edge; no grant SHALL occur in a cycle where reset is high.

Verification
REQ-032 After reset, req0 op=010 a0=5 b0=7, rsp_ready=1 -> gnt0 pulse at T, alu_cntrl=010 at T+1, rsp_valid at T+2 with rsp_id=0, rsp_result=12, rsp_flags=0000.
REQ-033 req1 op=011 a1=5 b1=5 -> rsp_id=1, rsp_result=0, rsp_flags=0101 (zero, carry).
REQ-034 req0 and req1 held high continuously, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0, and each grant is 3 cycles after the previous one.
REQ-035 Response held with rsp_ready=0 for 5 cycles while req1 is high -> rsp outputs stay stable, no gnt; rsp_ready=1 -> accepted; gnt1 in the next cycle.
REQ-036 Reset pulse during EXEC -> rsp_valid never rises, all outputs return to their reset values; a subsequent req0 op=000 b0=0xFF -> rsp_result=0xFF.
REQ-037 a0=0x7FFF_FFFF_FFFF_FFFF, b0=1, op=010 -> rsp_result=0x8000_0000_0000_0000, rsp_flags=1010 (negative, overflow).
